// File: rtl/gpio_bank.sv
// GPIO bank with an AHB-Lite register interface, input synchronisers and edge interrupts.
// Latency: writes land on the data-phase edge; reads are combinational from the registered address.
// Backpressure: none, because HREADYOUT is tied high and a transfer is accepted every cycle.
//
// Ports:
//   HCLK, HRESETn             clock and synchronous active-low reset
//   HADDR/HTRANS/HWRITE/HSEL  AHB-Lite address phase, captured when HREADY=1
//   HWDATA                    write data, used in the data phase
//   HRDATA, HREADYOUT         read data (zero-extended above WIDTH) and ready (always 1)
//   GPIOIN                    asynchronous pin inputs
//   GPIOOUT, GPIOEN           output data and output enable (DIR)
//   GPIOINT                   interrupt, the OR of all INTSTAT bits
module gpio_bank #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   input  logic [31:0]      HWDATA,
   input  logic             HWRITE,
   input  logic             HSEL,
   input  logic             HREADY,
   input  logic [WIDTH-1:0] GPIOIN,
   output logic             HREADYOUT,
   output logic [31:0]      HRDATA,
   output logic [WIDTH-1:0] GPIOOUT,
   output logic [WIDTH-1:0] GPIOEN,
   output logic             GPIOINT
);

   localparam logic [7:0] A_DATAIN  = 8'h00;
   localparam logic [7:0] A_DATAOUT = 8'h04;
   localparam logic [7:0] A_DIR     = 8'h08;
   localparam logic [7:0] A_INTEN   = 8'h0C;
   localparam logic [7:0] A_INTPOL  = 8'h10;
   localparam logic [7:0] A_INTSTAT = 8'h14;
   localparam logic [7:0] A_OUTSET  = 8'h18;
   localparam logic [7:0] A_OUTCLR  = 8'h1C;

   // Registered address phase
   logic [7:0] addr_q, addr_d;
   logic       sel_q, sel_d;
   logic       write_q, write_d;
   logic       trans_q, trans_d;

   // Register file
   logic [WIDTH-1:0] dataout_q, dataout_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] inten_q, inten_d;
   logic [WIDTH-1:0] intpol_q, intpol_d;
   logic [WIDTH-1:0] intstat_q, intstat_d;

   // Input synchroniser and previous-value register
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;

   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] wdat;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] rd_val;
   logic             wr_en;

   // Only HADDR[7:0], HTRANS[1] and HWDATA[WIDTH-1:0] carry meaning here.
   logic unused_bits;
   assign unused_bits = ^{HADDR[31:8], HTRANS[0], HWDATA};

   assign din   = sync_q[SYNC_STAGES-1];
   assign wdat  = HWDATA[WIDTH-1:0];
   assign wr_en = sel_q & write_q & trans_q;

   // Polarity bit picks rising (1) or falling (0) per pin; DIR plays no part.
   assign edge_det = (intpol_q & din & ~prev_q) | (~intpol_q & ~din & prev_q);

   always_comb begin
      addr_d    = addr_q;
      sel_d     = sel_q;
      write_d   = write_q;
      trans_d   = trans_q;
      dataout_d = dataout_q;
      dir_d     = dir_q;
      inten_d   = inten_q;
      intpol_d  = intpol_q;
      w1c       = '0;

      if (HREADY) begin
         addr_d  = HADDR[7:0];
         sel_d   = HSEL;
         write_d = HWRITE;
         trans_d = HTRANS[1];
      end

      if (wr_en) begin
         case (addr_q)
            A_DATAOUT: dataout_d = wdat;
            A_DIR:     dir_d     = wdat;
            A_INTEN:   inten_d   = wdat;
            A_INTPOL:  intpol_d  = wdat;
            A_INTSTAT: w1c       = wdat;
            A_OUTSET:  dataout_d = dataout_q | wdat;
            A_OUTCLR:  dataout_d = dataout_q & ~wdat;
            default:   ;
         endcase
      end

      // A fresh qualifying edge overrides a same-cycle write-1-to-clear.
      intstat_d = (intstat_q & ~w1c) | (edge_det & inten_q);
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         addr_q    <= '0;
         sel_q     <= 1'b0;
         write_q   <= 1'b0;
         trans_q   <= 1'b0;
         dataout_q <= '0;
         dir_q     <= '0;
         inten_q   <= '0;
         intpol_q  <= '0;
         intstat_q <= '0;
         prev_q    <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         addr_q    <= addr_d;
         sel_q     <= sel_d;
         write_q   <= write_d;
         trans_q   <= trans_d;
         dataout_q <= dataout_d;
         dir_q     <= dir_d;
         inten_q   <= inten_d;
         intpol_q  <= intpol_d;
         intstat_q <= intstat_d;
         prev_q    <= din;
         sync_q[0] <= GPIOIN;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_comb begin
      rd_val = '0;
      case (addr_q)
         A_DATAIN:  rd_val = din;
         A_DATAOUT: rd_val = dataout_q;
         A_DIR:     rd_val = dir_q;
         A_INTEN:   rd_val = inten_q;
         A_INTPOL:  rd_val = intpol_q;
         A_INTSTAT: rd_val = intstat_q;
         default:   rd_val = '0;
      endcase
      HRDATA             = '0;
      HRDATA[WIDTH-1:0]  = rd_val;
   end

   assign HREADYOUT = 1'b1;
   assign GPIOOUT   = dataout_q;
   assign GPIOEN    = dir_q;
   assign GPIOINT   = |intstat_q;

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic        HSEL;
   logic        HREADY;
   logic [15:0] GPIOIN;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic [15:0] GPIOOUT;
   logic [15:0] GPIOEN;
   logic        GPIOINT;

   logic        hreadyout8;
   logic [31:0] hrdata8;
   logic [7:0]  gpioout8;
   logic [7:0]  gpioen8;
   logic        gpioint8;

   always #5 HCLK = ~HCLK;

   gpio_bank #(.WIDTH(16), .SYNC_STAGES(2)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HREADY(HREADY),
      .GPIOIN(GPIOIN), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
      .GPIOOUT(GPIOOUT), .GPIOEN(GPIOEN), .GPIOINT(GPIOINT)
   );

   gpio_bank #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HREADY(HREADY),
      .GPIOIN(GPIOIN[7:0]), .HREADYOUT(hreadyout8), .HRDATA(hrdata8),
      .GPIOOUT(gpioout8), .GPIOEN(gpioen8), .GPIOINT(gpioint8)
   );

   typedef struct {
      bit          is_wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic [15:0] exp_out;
      logic [15:0] exp_en;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HADDR  = 32'h0;
   endtask

   task automatic addr_phase(input logic [7:0] a, input logic wr);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = wr;
      HADDR  = {24'h0, a};
   endtask

   task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
      addr_phase(a, 1'b1);
      tick();
      idle();
      HWDATA = d;
      tick();
   endtask

   // Expected read data goes on the scoreboard when the address is issued
   // and comes off when the data phase presents HRDATA.
   task automatic ahb_rd(input logic [7:0] a, input logic [31:0] exp, input string name);
      logic [31:0] got;
      exp_q.push_back(exp);
      addr_phase(a, 1'b0);
      tick();
      idle();
      got = HRDATA;
      check(name, got, exp_q.pop_front());
   endtask

   initial begin
      HRESETn = 1'b0;
      HREADY  = 1'b1;
      HWDATA  = 32'h0;
      GPIOIN  = 16'hFFFF;
      idle();

      // Reset holds everything at zero even with pins high
      tick();
      check("rst_gpioout", {16'h0, GPIOOUT}, 32'h0);
      check("rst_gpioen", {16'h0, GPIOEN}, 32'h0);
      check("rst_gpioint", {31'h0, GPIOINT}, 32'h0);
      check("rst_hrdata", HRDATA, 32'h0);
      check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
      repeat (2) tick();
      HRESETn = 1'b1;
      repeat (5) tick();
      check("no_int_after_reset", {31'h0, GPIOINT}, 32'h0);
      ahb_rd(8'h00, 32'h0000FFFF, "datain_high");

      // Synchroniser latency: value before edge N visible after edge N+1
      GPIOIN = 16'h0000;
      addr_phase(8'h00, 1'b0);
      repeat (4) tick();
      check("datain_zero", HRDATA, 32'h0);
      GPIOIN = 16'h8001;
      tick();
      check("datain_after_n", HRDATA, 32'h0);
      tick();
      check("datain_after_n1", HRDATA, 32'h00008001);
      idle();
      GPIOIN = 16'h0000;
      repeat (4) tick();

      // Register map table
      vecs.push_back('{1'b1, 8'h04, 32'h0000A5A5, 32'h0, 16'hA5A5, 16'h0000});
      vecs.push_back('{1'b1, 8'h18, 32'h0000000F, 32'h0, 16'hA5AF, 16'h0000});
      vecs.push_back('{1'b1, 8'h1C, 32'h00000100, 32'h0, 16'hA4AF, 16'h0000});
      vecs.push_back('{1'b0, 8'h04, 32'h0, 32'h0000A4AF, 16'h0, 16'h0});
      vecs.push_back('{1'b1, 8'h08, 32'h0000F0F0, 32'h0, 16'hA4AF, 16'hF0F0});
      vecs.push_back('{1'b0, 8'h08, 32'h0, 32'h0000F0F0, 16'h0, 16'h0});
      vecs.push_back('{1'b1, 8'h00, 32'h00001234, 32'h0, 16'hA4AF, 16'hF0F0});
      vecs.push_back('{1'b0, 8'h00, 32'h0, 32'h00000000, 16'h0, 16'h0});
      vecs.push_back('{1'b0, 8'h18, 32'h0, 32'h00000000, 16'h0, 16'h0});
      vecs.push_back('{1'b0, 8'h1C, 32'h0, 32'h00000000, 16'h0, 16'h0});
      vecs.push_back('{1'b1, 8'h20, 32'h0000FFFF, 32'h0, 16'hA4AF, 16'hF0F0});
      vecs.push_back('{1'b0, 8'h20, 32'h0, 32'h00000000, 16'h0, 16'h0});
      vecs.push_back('{1'b1, 8'h0C, 32'h00005555, 32'h0, 16'hA4AF, 16'hF0F0});
      vecs.push_back('{1'b0, 8'h0C, 32'h0, 32'h00005555, 16'h0, 16'h0});
      vecs.push_back('{1'b1, 8'h10, 32'h00003333, 32'h0, 16'hA4AF, 16'hF0F0});
      vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h00003333, 16'h0, 16'h0});
      vecs.push_back('{1'b1, 8'h04, 32'h12345678, 32'h0, 16'h5678, 16'hF0F0});
      vecs.push_back('{1'b0, 8'h04, 32'h0, 32'h00005678, 16'h0, 16'h0});
      vecs.push_back('{1'b0, 8'h14, 32'h0, 32'h00000000, 16'h0, 16'h0});
      vecs.push_back('{1'b1, 8'h08, 32'h00000000, 32'h0, 16'h5678, 16'h0000});
      vecs.push_back('{1'b0, 8'h05, 32'h0, 32'h00000000, 16'h0, 16'h0});

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_wr) begin
            ahb_wr(vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_gpioout", i), {16'h0, GPIOOUT}, {16'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_gpioen", i), {16'h0, GPIOEN}, {16'h0, vecs[i].exp_en});
         end else begin
            ahb_rd(vecs[i].addr, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
         end
      end

      // Rising-edge interrupt timing and W1C
      ahb_wr(8'h0C, 32'h0);
      ahb_wr(8'h14, 32'hFFFF);
      ahb_wr(8'h10, 32'h1);
      ahb_wr(8'h0C, 32'h1);
      ahb_rd(8'h14, 32'h0, "intstat_clean");
      GPIOIN = 16'h0001;
      tick();
      check("int_after_n", {31'h0, GPIOINT}, 32'h0);
      tick();
      check("int_after_n1", {31'h0, GPIOINT}, 32'h0);
      tick();
      check("int_after_n2", {31'h0, GPIOINT}, 32'h1);
      ahb_rd(8'h14, 32'h1, "intstat_set");
      ahb_wr(8'h14, 32'h1);
      check("int_w1c", {31'h0, GPIOINT}, 32'h0);
      ahb_rd(8'h14, 32'h0, "intstat_cleared");

      // Falling edge ignored under rising polarity; INTEN=0 keeps status
      GPIOIN = 16'h0000;
      repeat (4) tick();
      check("no_int_on_fall", {31'h0, GPIOINT}, 32'h0);
      GPIOIN = 16'h0001;
      repeat (4) tick();
      check("int_rise_again", {31'h0, GPIOINT}, 32'h1);
      ahb_wr(8'h0C, 32'h0);
      check("int_kept_inten0", {31'h0, GPIOINT}, 32'h1);
      ahb_rd(8'h14, 32'h1, "intstat_kept");
      ahb_wr(8'h14, 32'h1);
      check("int_w1c_2", {31'h0, GPIOINT}, 32'h0);

      // Set wins over a same-cycle W1C
      GPIOIN = 16'h0000;
      ahb_wr(8'h0C, 32'h1);
      repeat (3) tick();
      check("int_quiet", {31'h0, GPIOINT}, 32'h0);
      GPIOIN = 16'h0001;
      tick();
      addr_phase(8'h14, 1'b1);
      tick();
      idle();
      HWDATA = 32'h1;
      tick();
      check("set_wins_int", {31'h0, GPIOINT}, 32'h1);
      ahb_rd(8'h14, 32'h1, "set_wins_stat");

      // Back-to-back write then read of the same register
      addr_phase(8'h0C, 1'b1);
      tick();
      HWDATA = 32'h000000AA;
      addr_phase(8'h0C, 1'b0);
      tick();
      idle();
      check("b2b_read", HRDATA, 32'h000000AA);

      // Address phase with HREADY low is not captured
      HREADY = 1'b0;
      addr_phase(8'h08, 1'b1);
      tick();
      HREADY = 1'b1;
      idle();
      HWDATA = 32'hFFFF;
      tick();
      tick();
      check("hready_low_ignored", {16'h0, GPIOEN}, 32'h0);

      // Narrow instance truncates and zero-extends
      ahb_wr(8'h04, 32'hFFFFFFFF);
      check("w8_gpioout", {24'h0, gpioout8}, 32'h000000FF);
      check("w16_gpioout", {16'h0, GPIOOUT}, 32'h0000FFFF);
      exp_q.push_back(32'h000000FF);
      addr_phase(8'h04, 1'b0);
      tick();
      idle();
      check("w8_read", hrdata8, exp_q.pop_front());

      // One-edge reset mid-transfer with DIR and INTSTAT populated
      GPIOIN = 16'h0000;
      repeat (3) tick();
      ahb_wr(8'h08, 32'hFFFF);
      check("dir_full", {16'h0, GPIOEN}, 32'h0000FFFF);
      check("int_before_rst", {31'h0, GPIOINT}, 32'h1);
      addr_phase(8'h04, 1'b1);
      tick();
      idle();
      HWDATA  = 32'h5A5A;
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1;
      check("rst2_gpioen", {16'h0, GPIOEN}, 32'h0);
      check("rst2_gpioint", {31'h0, GPIOINT}, 32'h0);
      check("rst2_gpioout", {16'h0, GPIOOUT}, 32'h0);
      check("rst2_hrdata", HRDATA, 32'h0);
      for (int a = 0; a <= 8'h14; a += 4) begin
         ahb_rd(8'(a), 32'h0, $sformatf("rst2_rd_%02h", a));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, meaning number of GPIO pins, legal range 1..32.
- REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth, legal range 2..3.
- REQ-003 SHALL have port HCLK  input  1  single clock, all logic on rising edge.
- REQ-004 SHALL have port HRESETn  input  1  reset, synchronous and active-low.
- REQ-005 SHALL have AHB-Lite subordinate inputs HADDR 32, HTRANS 2, HWDATA 32, HWRITE 1, HSEL 1, HREADY 1.
- REQ-006 SHALL have port GPIOIN  input  WIDTH  asynchronous pin inputs.
- REQ-007 SHALL have port HREADYOUT  output  1  tied 1, no wait states.
- REQ-008 SHALL have port HRDATA  output  32  read data.
- REQ-009 SHALL have port GPIOOUT  output  WIDTH  output data register.
- REQ-010 SHALL have port GPIOEN  output  WIDTH  output enable, equals DIR.
- REQ-011 SHALL have port GPIOINT  output  1  interrupt, equals OR of INTSTAT.

Function
- REQ-012 SHALL register HADDR, HTRANS, HWRITE and HSEL at each rising edge where HREADY=1 (address phase).
- REQ-013 SHALL perform a write in the data phase when the registered HSEL=1, HWRITE=1 and HTRANS[1]=1, using HWDATA[WIDTH-1:0] and registered HADDR[7:0].
- REQ-014 SHALL decode the following map on HADDR[7:0]:
  - 0x00 DATAIN, RO: synchronised pins.
  - 0x04 DATAOUT, RW.
  - 0x08 DIR, RW; 1 = output.
  - 0x0C INTEN, RW.
  - 0x10 INTPOL, RW; 1 = rising edge, 0 = falling edge.
  - 0x14 INTSTAT, RO and write-1-to-clear.
  - 0x18 OUTSET, WO.
  - 0x1C OUTCLR, WO.
- REQ-015 SHALL drive HRDATA combinationally from the registered address, zero-extended above WIDTH.
- REQ-016 SHALL return 0 on reads of OUTSET, OUTCLR and unmapped offsets.
- REQ-017 SHALL ignore writes to DATAIN and to unmapped offsets.
- REQ-018 SHALL OR HWDATA into DATAOUT on an OUTSET write, in a single cycle.
- REQ-019 SHALL AND-NOT HWDATA from DATAOUT on an OUTCLR write, in a single cycle.
- REQ-020 SHALL pass GPIOIN through a SYNC_STAGES flop chain; a GPIOIN value stable before edge N SHALL be readable in DATAIN after edge N+SYNC_STAGES-1.
- REQ-021 SHALL hold a previous-value register of the synchroniser output and detect the per-bit edge selected by INTPOL by comparing against it.
- REQ-022 SHALL set an INTSTAT bit at the edge following edge detection, only when the matching INTEN bit is 1.
- REQ-023 SHALL, for the 2-stage case, assert GPIOINT after edge N+2 for a GPIOIN change before edge N.
- REQ-024 SHALL keep each INTSTAT bit set until a 1 is written to it at 0x14.
- REQ-025 SHALL NOT clear INTSTAT bits when INTEN is cleared; GPIOINT SHALL follow INTSTAT regardless of INTEN.
- REQ-026 SHALL let set win over clear when a W1C write and a new qualifying edge hit the same bit in the same cycle.
- REQ-027 SHALL apply a pin's edge detection regardless of its DIR setting.
- REQ-028 SHALL drive GPIOOUT = DATAOUT and GPIOEN = DIR directly from registers; a write SHALL be visible on the pins after the data-phase edge.
- REQ-029 SHALL accept back-to-back transfers every cycle; a read of a register in the cycle after a write to it SHALL return the new value.

Reset
- REQ-030 SHALL, on HRESETn=0 at a rising edge, clear DATAOUT, DIR, INTEN, INTPOL, INTSTAT, the synchroniser chain, the previous-value register and the registered address-phase signals to 0.
- REQ-031 SHALL hold GPIOOUT=0, GPIOEN=0, GPIOINT=0 and HRDATA=0 from the first reset edge until reset is released.
- REQ-032 SHALL abort any transfer in flight when reset is asserted mid-transfer, with no register updated.
- REQ-033 SHALL NOT raise an interrupt after reset release while GPIOIN is high, because INTEN=0.

Verification
- REQ-034 SHALL cover: write 0x04=0xA5A5, then OUTSET 0x000F, then OUTCLR 0x0100 -> GPIOOUT 0xA5A5, 0xA5AF, 0xA4AF on successive data-phase edges.
- REQ-035 SHALL cover: GPIOIN 0x0000->0x8001 before edge N (2 stages) -> read 0x00 returns 0x8001 after edge N+1 and 0x0000 before it.
- REQ-036 SHALL cover: INTEN=0x0001, INTPOL=0x0001, GPIOIN[0] rises -> INTSTAT=0x0001 and GPIOINT=1 after edge N+2; W1C 0x0001 -> GPIOINT=0.
- REQ-037 SHALL cover: W1C to bit 0 in the same cycle as a new rising edge on bit 0 -> INTSTAT[0] stays 1.
- REQ-038 SHALL cover: WIDTH=8 instance, write 0x04=0xFFFF_FFFF -> GPIOOUT=0xFF and read 0x04 returns 0x0000_00FF.
- REQ-039 SHALL cover: HRESETn=0 for one edge after DIR=0xFFFF and INTSTAT nonzero -> GPIOEN=0, GPIOINT=0, and all reads return 0.
